// File: rtl/montinv_pkg.sv
// Shared types and helpers for the Kaliski modular inverter.
package montinv_pkg;

  localparam logic [1:0] MODE_ALMOST  = 2'd0;
  localparam logic [1:0] MODE_CLASSIC = 2'd1;
  localparam logic [1:0] MODE_MONT    = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_FIX, S_PH2, S_DONE} state_t;
  typedef enum logic {F_IDLE, F_RUN} fix_state_t;

  function automatic int two_width(input int w);
    return 2 * w;
  endfunction

  // Trailing-zero count of the low three bits, saturating at 3.
  function automatic logic [1:0] tz3(input logic [2:0] x);
    if (x[0])      return 2'd0;
    else if (x[1]) return 2'd1;
    else if (x[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/montinv_fix.sv
// Phase-2 correction: repeated modular halving or doubling of r, cnt times.
module montinv_fix
  import montinv_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CWID  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dbl,
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] p,
  input  logic [CWID-1:0]  cnt_in,
  output logic             done,
  output logic [WIDTH-1:0] r_out,
  output fix_state_t       dbg_state
);

  fix_state_t      state_q, state_d;
  logic [WIDTH:0]  r_q, r_sum, r_half, r_t, r_dbl, r_next;
  logic [CWID-1:0] cnt_q;
  logic            dbl_q;

  // r stays below p here, so the sum and the doubled value fit WIDTH+1 bits.
  assign r_sum  = r_q + {1'b0, p};
  assign r_half = r_q[0] ? {1'b0, r_sum[WIDTH:1]} : {1'b0, r_q[WIDTH:1]};
  assign r_t    = {r_q[WIDTH-1:0], 1'b0};
  assign r_dbl  = (r_t >= {1'b0, p}) ? (r_t - {1'b0, p}) : r_t;
  assign r_next = dbl_q ? r_dbl : r_half;

  assign r_out     = r_q[WIDTH-1:0];
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == F_IDLE && start) begin
        r_q   <= r_in;
        cnt_q <= cnt_in;
        dbl_q <= dbl;
      end else if (state_q == F_RUN && cnt_q != '0) begin
        r_q   <= r_next;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      F_IDLE: if (start) state_d = F_RUN;
      F_RUN: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = F_IDLE;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

endmodule

// File: rtl/montinv_core.sv
// Modular inverter: Kaliski almost-inverse followed by a mode-selected correction.
// Handshake: start is sampled only in S_IDLE; busy rises the edge after acceptance and
// falls on the same edge that raises done; done is a one-cycle pulse with dout/exp/err valid.
module montinv_core
  import montinv_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CWID  = 10,
  parameter int NR    = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] mod,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] dout,
  output logic [CWID-1:0]  exp,
  output state_t           dbg_state,
  output fix_state_t       dbg_fix_state
);

  localparam logic [CWID-1:0] NR_C = CWID'(NR);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, u_q, v_q, diff_uv, diff_vu;
  logic [WIDTH:0]   r_q, s_q, sum_rs, r_fix;
  logic [CWID-1:0]  k_q, fix_cnt;
  logic [1:0]       mode_q, tz_u, tz_v;
  logic             err_f, start_bad, fix_dbl, fix_start, fix_done;
  logic [WIDTH-1:0] fix_r;

  assign start_bad = ~mod[0] | (mod < WIDTH'(3)) | (din == '0) | (din >= mod);
  assign tz_u      = tz3(u_q[2:0]);
  assign tz_v      = tz3(v_q[2:0]);
  assign diff_uv   = u_q - v_q;
  assign diff_vu   = v_q - u_q;
  assign sum_rs    = r_q + s_q;
  // Phase 1 leaves r in [0, 2p); map it to p - r mod p.
  assign r_fix     = (r_q >= {1'b0, p_q}) ? ({p_q, 1'b0} - r_q) : ({1'b0, p_q} - r_q);
  assign fix_start = (state_q == S_FIX);
  assign dbg_state = state_q;

  always_comb begin
    fix_cnt = '0;
    fix_dbl = 1'b0;
    case (mode_q)
      MODE_CLASSIC: fix_cnt = k_q;
      MODE_MONT: begin
        if (k_q >= NR_C) begin
          fix_cnt = k_q - NR_C;
        end else begin
          fix_cnt = NR_C - k_q;
          fix_dbl = 1'b1;
        end
      end
      default: ;
    endcase
  end

  montinv_fix #(.WIDTH(WIDTH), .CWID(CWID)) u_fix (
    .clk       (clk),
    .rst       (rst),
    .start     (fix_start),
    .dbl       (fix_dbl),
    .r_in      (r_fix),
    .p         (p_q),
    .cnt_in    (fix_cnt),
    .done      (fix_done),
    .r_out     (fix_r),
    .dbg_state (dbg_fix_state)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = start_bad ? S_DONE : S_PH1;
      S_PH1:   if (v_q == '0) state_d = (u_q != WIDTH'(1)) ? S_DONE : S_FIX;
      S_FIX:   state_d = S_PH2;
      S_PH2:   if (fix_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      mode_q <= MODE_ALMOST;
      u_q    <= '0;
      v_q    <= '0;
      r_q    <= '0;
      s_q    <= '0;
      k_q    <= '0;
      err_f  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      dout   <= '0;
      exp    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            p_q    <= mod;
            mode_q <= (mode == 2'd3) ? MODE_ALMOST : mode;
            u_q    <= mod;
            v_q    <= din;
            r_q    <= '0;
            s_q    <= (WIDTH+1)'(1);
            k_q    <= '0;
            err_f  <= start_bad;
            busy   <= 1'b1;
          end
        end
        S_PH1: begin
          if (v_q == '0) begin
            err_f <= (u_q != WIDTH'(1));
          end else if (tz_u != 2'd0) begin
            u_q <= u_q >> tz_u;
            s_q <= s_q << tz_u;
            k_q <= k_q + CWID'(tz_u);
          end else if (tz_v != 2'd0) begin
            v_q <= v_q >> tz_v;
            r_q <= r_q << tz_v;
            k_q <= k_q + CWID'(tz_v);
          end else if (u_q > v_q) begin
            u_q <= diff_uv >> 1;
            r_q <= sum_rs;
            s_q <= s_q << 1;
            k_q <= k_q + 1'b1;
          end else begin
            v_q <= diff_vu >> 1;
            s_q <= sum_rs;
            r_q <= r_q << 1;
            k_q <= k_q + 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          err  <= err_f;
          dout <= err_f ? '0 : fix_r;
          exp  <= err_f ? '0 : k_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montinv_core.sv
// Bench for montinv_core at WIDTH=8, NR=8: known vectors, random operands, corner sequences.
module tb_montinv_core;
  import montinv_pkg::*;

  localparam int W   = 8;
  localparam int CW  = 5;
  localparam int NRP = 8;

  logic          clk, rst, start;
  logic [W-1:0]  din, mod, dout;
  logic [1:0]    mode;
  logic          busy, done, err;
  logic [CW-1:0] exp;
  state_t        dbg_state;
  fix_state_t    dbg_fix_state;

  montinv_core #(.WIDTH(W), .CWID(CW), .NR(NRP)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .din           (din),
    .mod           (mod),
    .mode          (mode),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .dout          (dout),
    .exp           (exp),
    .dbg_state     (dbg_state),
    .dbg_fix_state (dbg_fix_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic          err;
    logic          chk_k;
    logic [CW-1:0] k;
    logic [W-1:0]  dout;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat_max;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int bitlen(input int x);
    int n = 0;
    while (x != 0) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  function automatic res_t model(input int a, input int p, input int m);
    res_t r;
    int u, v, k, inv, pw, mm, sc;
    r = '0;
    if ((p % 2) == 0 || p < 3 || a == 0 || a >= p) begin
      r.err = 1'b1; r.chk_k = 1'b1;
      return r;
    end
    if (gcd(a, p) != 1) begin
      r.err = 1'b1; r.chk_k = 1'b0;
      return r;
    end
    u = p; v = a; k = 0;
    while (v != 0) begin
      if ((u % 2) == 0)      u = u / 2;
      else if ((v % 2) == 0) v = v / 2;
      else if (u > v)        u = (u - v) / 2;
      else                   v = (v - u) / 2;
      k++;
    end
    inv = 0;
    for (int x = 1; x < p; x++) if ((a * x) % p == 1) inv = x;
    mm = (m == 3) ? 0 : m;
    sc = (mm == 0) ? k : ((mm == 2) ? NRP : 0);
    pw = 1;
    repeat (sc) pw = (pw * 2) % p;
    pw = (inv * pw) % p;
    r.dout  = pw[W-1:0];
    r.k     = k[CW-1:0];
    r.chk_k = 1'b1;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic start_op(input int a, input int p, input int m);
    din   = a[W-1:0];
    mod   = p[W-1:0];
    mode  = m[1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("done_single_pulse", int'(done), 0);
  endtask

  task automatic wait_done(input string tag, output int lat);
    res_t e;
    lat = 1;
    while (!done && lat < lat_max + 8) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", tag, lat);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_extra_done: got done expected none", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_dout"}, int'(dout), int'(e.dout));
    check({tag, "_err"}, int'(err), int'(e.err));
    check({tag, "_busy_low"}, int'(busy), 0);
    if (e.chk_k) check({tag, "_exp"}, int'(exp), int'(e.k));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int a; int p; int m; int dout; int k; bit err; bit chk_k; bit lat2;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int   lat, a, p, m, bl;
    res_t r;

    lat_max = two_width(W) + 1 + 1 + ((two_width(W) > NRP) ? two_width(W) : NRP) + 1 + 2;

    tbl[0]  = '{5, 23, 0, 22, 6, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{5, 23, 1, 14, 6, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5, 23, 2, 19, 6, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{5, 23, 3, 22, 6, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{22, 23, 1, 22, 8, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{22, 23, 2, 20, 8, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1, 3, 0, 1, 2, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1, 3, 1, 1, 2, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{6, 21, 1, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{0, 23, 0, 0, 0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{5, 22, 1, 0, 0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{23, 23, 0, 0, 0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{0, 1, 2, 0, 0, 1'b1, 1'b1, 1'b1};

    // ---------------- reset ----------------
    rst = 1'b1; start = 1'b0; din = '0; mod = '0; mode = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_exp", int'(exp), 0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 13; i++) begin
      r       = '0;
      r.err   = tbl[i].err;
      r.chk_k = tbl[i].chk_k;
      r.k     = tbl[i].k[CW-1:0];
      r.dout  = tbl[i].dout[W-1:0];
      exp_q.push_back(r);
      start_op(tbl[i].a, tbl[i].p, tbl[i].m);
      wait_done($sformatf("tbl%0d", i), lat);
      if (tbl[i].lat2) check($sformatf("tbl%0d_err_latency", i), lat, 2);
      else             check($sformatf("tbl%0d_latency_bound", i), int'(lat <= lat_max), 1);
    end
    @(negedge clk);
    check("done_pulse_width", int'(done), 0);

    // ---------------- start while busy is ignored ----------------
    exp_q.push_back(model(5, 23, 1));
    start_op(5, 23, 1);
    repeat (3) @(negedge clk);
    din = 8'd7; mod = 8'd29; mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_restart", lat);
    @(negedge clk);
    check("busy_restart_no_second_done", int'(done), 0);
    check("busy_restart_idle", int'(busy), 0);

    // ---------------- reset mid phase 1 ----------------
    start_op(22, 23, 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_exp", int'(exp), 0);
    exp_q.push_back(model(5, 23, 0));
    start_op(5, 23, 0);
    wait_done("after_rst", lat);

    // ---------------- back-to-back: start in the done cycle ----------------
    exp_q.push_back(model(22, 23, 2));
    start_op(22, 23, 2);
    wait_done("b2b_first", lat);
    exp_q.push_back(model(5, 23, 1));
    start_op(5, 23, 1);
    wait_done("b2b_second", lat);
    @(negedge clk);
    check("b2b_no_dup_done", int'(done), 0);

    // ---------------- random operands vs model ----------------
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        p = int'($urandom_range(0, 255));
        a = int'($urandom_range(0, 255));
      end else begin
        p = 2 * int'($urandom_range(1, 127)) + 1;
        a = int'($urandom_range(1, p - 1));
      end
      m = int'($urandom_range(0, 3));
      r = model(a, p, m);
      exp_q.push_back(r);
      start_op(a, p, m);
      wait_done($sformatf("rnd%0d_a%0d_p%0d_m%0d", n, a, p, m), lat);
      if (!r.err) begin
        bl = bitlen(p);
        check($sformatf("rnd%0d_k_range", n), int'(exp) >= bl && int'(exp) <= 2 * bl ? 1 : 0, 1);
        check($sformatf("rnd%0d_latency_bound", n), int'(lat <= lat_max), 1);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
